// File: rtl/oled_axil_pkg.sv
// Shared constants, FSM encodings and payload types for the OLED AXI4-Lite register responder.
package oled_axil_pkg;

   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef logic [2:0] wr_state_t;
   localparam wr_state_t WR_IDLE    = 3'd0;
   localparam wr_state_t WR_HAVE_AW = 3'd1;
   localparam wr_state_t WR_HAVE_W  = 3'd2;
   localparam wr_state_t WR_COMMIT  = 3'd3;
   localparam wr_state_t WR_RESP    = 3'd4;

   typedef logic [0:0] rd_state_t;
   localparam rd_state_t RD_IDLE = 1'b0;
   localparam rd_state_t RD_RESP = 1'b1;

   // One captured W beat, held until both halves of the write are present.
   typedef struct packed {
      logic [AXI_DATA_W-1:0] data;
      logic [AXI_STRB_W-1:0] strb;
   } wr_beat_t;

endpackage

// File: rtl/oled_axil_responder_if.sv
// AXI4-Lite channel bundle between the PS/VIP master and the OLED register responder.
interface oled_axil_responder_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
   logic [2:0]            S_AXI_AWPROT;
   logic                  S_AXI_AWVALID;
   logic                  S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0] S_AXI_WDATA;
   logic [STRB_W-1:0]     S_AXI_WSTRB;
   logic                  S_AXI_WVALID;
   logic                  S_AXI_WREADY;
   logic [1:0]            S_AXI_BRESP;
   logic                  S_AXI_BVALID;
   logic                  S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
   logic [2:0]            S_AXI_ARPROT;
   logic                  S_AXI_ARVALID;
   logic                  S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0] S_AXI_RDATA;
   logic [1:0]            S_AXI_RRESP;
   logic                  S_AXI_RVALID;
   logic                  S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/oled_axil_reg_bank.sv
// Register storage for the OLED controller: byte-strobed write port, combinational read
// mux and a one-cycle update pulse per register.
module oled_axil_reg_bank #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 4,
   parameter int unsigned IDX_W      = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [IDX_W-1:0]             wr_idx,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [DATA_WIDTH/8-1:0]      wr_strb,
   input  logic [IDX_W-1:0]             rd_idx,
   output logic [DATA_WIDTH-1:0]        rd_data_c,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]          reg_wr_pulse
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   // Storage update; the pulse is registered alongside the data so both appear together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               reg_wr_pulse[i] <= 1'b1;
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Unimplemented indices read as zero.
   always_comb begin
      rd_data_c = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_data_c = regs_q[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

endmodule

// File: rtl/oled_axil_responder.sv
// AXI4-Lite responder exposing the OLED controller register bank; one outstanding write
// (AW/W in either order) and one outstanding read, on independent channels.
module oled_axil_responder
   import oled_axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned NUM_REGS   = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   oled_axil_responder_if.slave            s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_q,
   output logic [NUM_REGS-1:0]             reg_wr_pulse
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;

   // Write channel state
   wr_state_t             wr_state_q, wr_state_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [IDX_W-1:0]      wr_idx_q;
   wr_beat_t              wr_beat_q;

   // Read channel state
   rd_state_t             rd_state_q, rd_state_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  aw_hs_c, w_hs_c, ar_hs_c;
   logic                  wr_in_range_c, rd_in_range_c, wr_en_c;
   logic [IDX_W-1:0]      rd_idx_c;
   logic [DATA_WIDTH-1:0] rd_data_c;
   logic                  unused_ok;

   assign aw_hs_c = s_axi.S_AXI_AWVALID & awready_q;
   assign w_hs_c  = s_axi.S_AXI_WVALID  & wready_q;
   assign ar_hs_c = s_axi.S_AXI_ARVALID & arready_q;

   // Byte offset bits alias to the word; PROT carries no meaning for this bank.
   assign rd_idx_c      = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign wr_in_range_c = ({1'b0, wr_idx_q} < (IDX_W+1)'(NUM_REGS));
   assign rd_in_range_c = ({1'b0, rd_idx_c} < (IDX_W+1)'(NUM_REGS));
   assign wr_en_c       = (wr_state_q == WR_COMMIT) && wr_in_range_c;
   assign unused_ok     = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                            s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   oled_axil_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_reg_bank (
      .clk          (ACLK),
      .rst          (ARESET),
      .wr_en        (wr_en_c),
      .wr_idx       (wr_idx_q),
      .wr_data      (wr_beat_q.data),
      .wr_strb      (wr_beat_q.strb),
      .rd_idx       (rd_idx_c),
      .rd_data_c    (rd_data_c),
      .reg_q        (reg_q),
      .reg_wr_pulse (reg_wr_pulse)
   );

   // Write FSM state and output registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state_q <= WR_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= AXI_RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
      end
   end

   // Address and data are captured independently so either may arrive first.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_idx_q  <= '0;
         wr_beat_q <= '0;
      end else begin
         if (aw_hs_c) begin
            wr_idx_q <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
         end
         if (w_hs_c) begin
            wr_beat_q.data <= s_axi.S_AXI_WDATA;
            wr_beat_q.strb <= s_axi.S_AXI_WSTRB;
         end
      end
   end

   always_comb begin
      wr_state_d = wr_state_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      case (wr_state_q)
         WR_IDLE: begin
            // Readies come up here, which also covers the first edge after reset.
            awready_d = 1'b1;
            wready_d  = 1'b1;
            if (aw_hs_c && w_hs_c) begin
               wr_state_d = WR_COMMIT;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
            end else if (aw_hs_c) begin
               wr_state_d = WR_HAVE_AW;
               awready_d  = 1'b0;
            end else if (w_hs_c) begin
               wr_state_d = WR_HAVE_W;
               wready_d   = 1'b0;
            end
         end
         WR_HAVE_AW: begin
            if (w_hs_c) begin
               wr_state_d = WR_COMMIT;
               wready_d   = 1'b0;
            end
         end
         WR_HAVE_W: begin
            if (aw_hs_c) begin
               wr_state_d = WR_COMMIT;
               awready_d  = 1'b0;
            end
         end
         WR_COMMIT: begin
            wr_state_d = WR_RESP;
            bvalid_d   = 1'b1;
            bresp_d    = wr_in_range_c ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
         end
         WR_RESP: begin
            if (s_axi.S_AXI_BREADY) begin
               wr_state_d = WR_IDLE;
               bvalid_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
            end
         end
         default: begin
            wr_state_d = WR_IDLE;
            awready_d  = 1'b0;
            wready_d   = 1'b0;
            bvalid_d   = 1'b0;
         end
      endcase
   end

   // Read FSM state and output registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= AXI_RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   // Read data is sampled from the bank before any same-edge commit lands.
   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      case (rd_state_q)
         RD_IDLE: begin
            arready_d = 1'b1;
            if (ar_hs_c) begin
               rd_state_d = RD_RESP;
               arready_d  = 1'b0;
               rvalid_d   = 1'b1;
               rdata_d    = rd_in_range_c ? rd_data_c : '0;
               rresp_d    = rd_in_range_c ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
         end
         RD_RESP: begin
            if (s_axi.S_AXI_RREADY) begin
               rd_state_d = RD_IDLE;
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
            arready_d  = 1'b0;
            rvalid_d   = 1'b0;
         end
      endcase
   end

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_oled_axil_responder.sv
// Bench for oled_axil_responder: a 4-register and a 3-register build driven in lockstep,
// checked against an array-based register model.
module tb_oled_axil_responder;
   import oled_axil_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   oled_axil_responder_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifa ();
   oled_axil_responder_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifb ();

   logic [127:0] q4;
   logic [95:0]  q3;
   logic [3:0]   p4;
   logic [2:0]   p3;

   oled_axil_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut4 (
      .ACLK(clk), .ARESET(rst), .s_axi(ifa), .reg_q(q4), .reg_wr_pulse(p4));
   oled_axil_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
      .ACLK(clk), .ARESET(rst), .s_axi(ifb), .reg_q(q3), .reg_wr_pulse(p3));

   // The 3-register build sees exactly the same master stimulus.
   assign ifb.S_AXI_AWADDR  = ifa.S_AXI_AWADDR;
   assign ifb.S_AXI_AWPROT  = ifa.S_AXI_AWPROT;
   assign ifb.S_AXI_AWVALID = ifa.S_AXI_AWVALID;
   assign ifb.S_AXI_WDATA   = ifa.S_AXI_WDATA;
   assign ifb.S_AXI_WSTRB   = ifa.S_AXI_WSTRB;
   assign ifb.S_AXI_WVALID  = ifa.S_AXI_WVALID;
   assign ifb.S_AXI_BREADY  = ifa.S_AXI_BREADY;
   assign ifb.S_AXI_ARADDR  = ifa.S_AXI_ARADDR;
   assign ifb.S_AXI_ARPROT  = ifa.S_AXI_ARPROT;
   assign ifb.S_AXI_ARVALID = ifa.S_AXI_ARVALID;
   assign ifb.S_AXI_RREADY  = ifa.S_AXI_RREADY;

   logic [31:0] m4 [4];
   logic [31:0] m3 [3];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old & ~mask) | (data & mask);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 4; i++) m4[i] = '0;
      for (int i = 0; i < 3; i++) m3[i] = '0;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) chk(tag, q4[32*i +: 32], m4[i]);
      for (int i = 0; i < 3; i++) chk(tag, q3[32*i +: 32], m3[i]);
   endtask

   // Entered and left on a falling edge.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, input bit poke_aw);
      bit aw_done = 0, w_done = 0, hs_aw, hs_w;
      int cyc = 0;
      int idx = int'(addr[3:2]);
      logic [1:0] exp_b3 = (idx < 3) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      ifa.S_AXI_AWADDR = addr;
      ifa.S_AXI_WDATA  = data;
      ifa.S_AXI_WSTRB  = strb;
      while (!(aw_done && w_done)) begin
         if (cyc > 100) begin
            chk("wr_timeout", 64'd1, 64'd0);
            ifa.S_AXI_AWVALID = 1'b0;
            ifa.S_AXI_WVALID  = 1'b0;
            return;
         end
         ifa.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
         ifa.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
         hs_aw = ifa.S_AXI_AWVALID && ifa.S_AXI_AWREADY;
         hs_w  = ifa.S_AXI_WVALID && ifa.S_AXI_WREADY;
         @(negedge clk);
         if (hs_aw) aw_done = 1;
         if (hs_w)  w_done  = 1;
         cyc++;
      end
      ifa.S_AXI_AWVALID = 1'b0;
      ifa.S_AXI_WVALID  = 1'b0;
      chk("bvalid_early", {ifa.S_AXI_BVALID, ifb.S_AXI_BVALID}, 2'b00);
      chk("pulse_early", {p4, p3}, 7'b0);
      @(negedge clk);
      m4[idx] = merge(m4[idx], data, strb);
      if (idx < 3) m3[idx] = merge(m3[idx], data, strb);
      chk("bvalid_lat", {ifa.S_AXI_BVALID, ifb.S_AXI_BVALID}, 2'b11);
      chk("pulse4", p4, 4'b0001 << idx);
      chk("pulse3", p3, (idx < 3) ? (3'b001 << idx) : 3'b000);
      check_regs("wr_regs");
      for (int s = 0; s < b_dly; s++) begin
         if (poke_aw) begin
            ifa.S_AXI_AWADDR  = ~addr;
            ifa.S_AXI_AWVALID = 1'b1;
         end
         chk("b_hold", {ifa.S_AXI_BVALID, ifb.S_AXI_BVALID, ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY},
             4'b1100);
         @(negedge clk);
      end
      ifa.S_AXI_AWVALID = 1'b0;
      ifa.S_AXI_AWADDR  = addr;
      ifa.S_AXI_BREADY  = 1'b1;
      chk("bvalid_at_rdy", {ifa.S_AXI_BVALID, ifb.S_AXI_BVALID}, 2'b11);
      chk("bresp4", ifa.S_AXI_BRESP, AXI_RESP_OKAY);
      chk("bresp3", ifb.S_AXI_BRESP, exp_b3);
      @(negedge clk);
      ifa.S_AXI_BREADY = 1'b0;
      chk("b_done", {ifa.S_AXI_BVALID, ifb.S_AXI_BVALID, ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY},
          4'b0011);
      chk("pulse_after", {p4, p3}, 7'b0);
   endtask

   // Entered and left on a falling edge; got4 returns what the 4-register build sent.
   task automatic axi_read(input logic [3:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] got4);
      bit done = 0, hs;
      int cyc = 0;
      int idx = int'(addr[3:2]);
      logic [31:0] exp4 = '0, exp3 = '0;
      logic [1:0]  exp_r3 = (idx < 3) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      got4 = '0;
      ifa.S_AXI_ARADDR = addr;
      while (!done) begin
         if (cyc > 100) begin
            chk("rd_timeout", 64'd1, 64'd0);
            ifa.S_AXI_ARVALID = 1'b0;
            return;
         end
         ifa.S_AXI_ARVALID = (cyc >= ar_dly);
         hs = ifa.S_AXI_ARVALID && ifa.S_AXI_ARREADY;
         if (hs) begin
            exp4 = m4[idx];
            exp3 = (idx < 3) ? m3[idx] : 32'h0;
         end
         @(negedge clk);
         if (hs) done = 1;
         cyc++;
      end
      ifa.S_AXI_ARVALID = 1'b0;
      got4 = ifa.S_AXI_RDATA;
      chk("rvalid", {ifa.S_AXI_RVALID, ifb.S_AXI_RVALID, ifa.S_AXI_ARREADY}, 3'b110);
      chk("rdata4", ifa.S_AXI_RDATA, exp4);
      chk("rresp4", ifa.S_AXI_RRESP, AXI_RESP_OKAY);
      chk("rdata3", ifb.S_AXI_RDATA, exp3);
      chk("rresp3", ifb.S_AXI_RRESP, exp_r3);
      for (int s = 0; s < r_dly; s++) begin
         @(negedge clk);
         chk("r_hold4", {ifa.S_AXI_RVALID, ifa.S_AXI_RDATA}, {1'b1, exp4});
         chk("r_hold3", {ifb.S_AXI_RVALID, ifb.S_AXI_RRESP, ifb.S_AXI_RDATA}, {1'b1, exp_r3, exp3});
      end
      ifa.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      ifa.S_AXI_RREADY = 1'b0;
      chk("r_done", {ifa.S_AXI_RVALID, ifb.S_AXI_RVALID, ifa.S_AXI_ARREADY}, 3'b001);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk(tag, {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_ARREADY, ifa.S_AXI_BVALID,
                ifa.S_AXI_RVALID, ifb.S_AXI_BVALID, ifb.S_AXI_RVALID}, 7'b0);
      chk({tag, "_data"}, {ifa.S_AXI_BRESP, ifa.S_AXI_RRESP, ifa.S_AXI_RDATA, p4, p3}, 43'b0);
   endtask

   task automatic release_reset();
      rst = 1'b0;
      #1;
      chk("rdy_before_edge", {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_ARREADY}, 3'b000);
      @(negedge clk);
      chk("rdy_after_edge", {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_ARREADY,
                             ifb.S_AXI_AWREADY}, 4'b1111);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] v;
      rst = 1'b1;
      ifa.S_AXI_AWADDR = '0; ifa.S_AXI_AWPROT = '0; ifa.S_AXI_AWVALID = 1'b0;
      ifa.S_AXI_WDATA  = '0; ifa.S_AXI_WSTRB  = '0; ifa.S_AXI_WVALID  = 1'b0;
      ifa.S_AXI_BREADY = 1'b0;
      ifa.S_AXI_ARADDR = '0; ifa.S_AXI_ARPROT = '0; ifa.S_AXI_ARVALID = 1'b0;
      ifa.S_AXI_RREADY = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_state");
      check_regs("reset_regs");
      release_reset();

      // Sequential fill then read-back.
      for (int i = 0; i < 4; i++) axi_write(4'(4*i), 32'(i + 1), 4'hF, 0, 0, i % 2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4*i), 0, i, rd);
         chk("seq_rd_const", rd, 64'(i + 1));
      end

      // W ahead of AW, then AW ahead of W.
      axi_write(4'h4, 32'hDEADBEEF, 4'hF, 3, 0, 0, 1'b0);
      chk("w_first_const", q4[63:32], 32'hDEADBEEF);
      axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 3, 0, 1'b0);
      chk("aw_first_const", q4[63:32], 32'hDEADBEEF);

      // Partial byte strobes.
      axi_write(4'h8, 32'h11223344, 4'hF, 0, 0, 0, 1'b0);
      axi_write(4'h8, 32'hAABBCCDD, 4'h5, 1, 0, 0, 1'b0);
      chk("strb_const", q4[95:64], 32'h11BB33DD);

      // Back-pressured B with a competing AW.
      axi_write(4'h0, 32'hCAFE0001, 4'hF, 0, 0, 5, 1'b1);

      // Out-of-range for the 3-register build, unaligned address aliasing.
      axi_write(4'hC, 32'h00000055, 4'hF, 0, 1, 0, 1'b0);
      axi_read(4'hC, 0, 1, rd);
      axi_read(4'h7, 1, 0, rd);
      chk("alias_const", rd, 32'hDEADBEEF);

      // Read captured on the commit edge of a write to the same register returns old data.
      fork
         axi_write(4'h4, 32'h600DCAFE, 4'hF, 0, 0, 0, 1'b0);
         axi_read(4'h4, 1, 0, rd);
      join
      chk("old_val_const", rd, 32'hDEADBEEF);
      chk("new_val_const", q4[63:32], 32'h600DCAFE);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         v = $urandom;
         if ($urandom_range(1, 0) == 1)
            axi_write(4'($urandom_range(15, 0)), v, 4'($urandom_range(15, 0)),
                      $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                      1'($urandom_range(1, 0)));
         else
            axi_read(4'($urandom_range(15, 0)), $urandom_range(2, 0), $urandom_range(3, 0), rd);
      end

      // Reset while holding an accepted address (HAVE_AW).
      axi_write(4'h0, 32'h12345678, 4'hF, 0, 0, 0, 1'b0);
      ifa.S_AXI_AWADDR  = 4'h4;
      ifa.S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      ifa.S_AXI_AWVALID = 1'b0;
      chk("have_aw_rdy", {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY}, 2'b01);
      rst = 1'b1;
      #1;
      clear_model();
      check_reset_outputs("rst_have_aw");
      check_regs("rst_have_aw_regs");
      @(negedge clk);
      release_reset();
      check_regs("post_rst_regs");

      // Reset while read data is stalled.
      axi_write(4'h8, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 1'b0);
      ifa.S_AXI_ARADDR  = 4'h8;
      ifa.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      ifa.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      chk("stall_rd", {ifa.S_AXI_RVALID, ifa.S_AXI_RDATA}, {1'b1, 32'hA5A5A5A5});
      rst = 1'b1;
      #1;
      clear_model();
      check_reset_outputs("rst_rvalid");
      check_regs("rst_rvalid_regs");
      @(negedge clk);
      release_reset();
      axi_read(4'h8, 0, 0, rd);
      chk("post_rst_rd", rd, 32'h0);
      axi_write(4'h4, 32'h0BADF00D, 4'hF, 0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
